// File: rtl/issue_queue_ctrl.sv
// Entry management for a 16-entry out-of-order issue queue: allocation, dense age
// tracking, tag wakeup, select-tree export and a registered single-entry issue slot.
module issue_queue_ctrl #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned AGE          = 5,
  parameter int unsigned TAG          = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [OPCODE_WIDTH-1:0]        disp_op,
  input  logic [TAG-1:0]                 disp_src1_tag,
  input  logic                           disp_src1_rdy,
  input  logic [TAG-1:0]                 disp_src2_tag,
  input  logic                           disp_src2_rdy,
  input  logic [TAG-1:0]                 disp_dst_tag,
  input  logic                           wk_valid,
  input  logic [TAG-1:0]                 wk_tag,
  output logic [DEPTH-1:0]               sel_req,
  output logic [DEPTH*OPCODE_WIDTH-1:0]  sel_op,
  output logic [DEPTH*AGE-1:0]           sel_age,
  input  logic                           gnt_valid,
  input  logic [3:0]                     gnt_addr,
  output logic                           iss_valid,
  output logic [OPCODE_WIDTH-1:0]        iss_op,
  output logic [TAG-1:0]                 iss_dst_tag,
  output logic [TAG-1:0]                 iss_src1_tag,
  output logic [TAG-1:0]                 iss_src2_tag,
  output logic [4:0]                     count
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 5;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] op;
    logic [TAG-1:0]          src1;
    logic                    rdy1;
    logic [TAG-1:0]          src2;
    logic                    rdy2;
    logic [TAG-1:0]          dst;
    logic [AGE-1:0]          age;
  } entry_t;

  entry_t                  ent_q [DEPTH];
  entry_t                  ent_d [DEPTH];
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    iss_valid_q, iss_valid_d;
  logic [OPCODE_WIDTH-1:0] iss_op_q, iss_op_d;
  logic [TAG-1:0]          iss_dst_q, iss_dst_d;
  logic [TAG-1:0]          iss_src1_q, iss_src1_d;
  logic [TAG-1:0]          iss_src2_q, iss_src2_d;

  logic [IDX_W-1:0]        free_idx;
  logic                    free_found;
  logic                    disp_fire;
  logic                    grant_fire;
  logic [AGE-1:0]          gnt_age;
  logic                    wk1, wk2;

  // Select-tree export straight from entry registers
  always_comb begin
    sel_req = '0;
    sel_op  = '0;
    sel_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_req[i]                              = valid_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
      sel_op[i*OPCODE_WIDTH +: OPCODE_WIDTH]  = ent_q[i].op;
      sel_age[i*AGE +: AGE]                   = ent_q[i].age;
    end
  end

  assign disp_ready = (count_q != CNT_W'(DEPTH));

  // Lowest-index free slot
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign grant_fire = gnt_valid & valid_q[gnt_addr] & sel_req[gnt_addr] & ~flush;
  assign gnt_age    = ent_q[gnt_addr].age;
  assign wk1        = wk_valid & (disp_src1_tag == wk_tag);
  assign wk2        = wk_valid & (disp_src2_tag == wk_tag);

  // Entry next-state: wakeup, age compaction, retire, allocate; flush overrides all
  always_comb begin
    valid_d     = valid_q;
    count_d     = count_q + CNT_W'(disp_fire) - CNT_W'(grant_fire);
    iss_valid_d = grant_fire;
    iss_op_d    = iss_op_q;
    iss_dst_d   = iss_dst_q;
    iss_src1_d  = iss_src1_q;
    iss_src2_d  = iss_src2_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (valid_q[i] && wk_valid) begin
        if (ent_q[i].src1 == wk_tag) ent_d[i].rdy1 = 1'b1;
        if (ent_q[i].src2 == wk_tag) ent_d[i].rdy2 = 1'b1;
      end
      if (grant_fire && valid_q[i] && (ent_q[i].age > gnt_age)) begin
        ent_d[i].age = ent_q[i].age - AGE'(1);
      end
    end
    if (grant_fire) begin
      valid_d[gnt_addr] = 1'b0;
      iss_op_d          = ent_q[gnt_addr].op;
      iss_dst_d         = ent_q[gnt_addr].dst;
      iss_src1_d        = ent_q[gnt_addr].src1;
      iss_src2_d        = ent_q[gnt_addr].src2;
    end
    if (disp_fire) begin
      valid_d[free_idx]     = 1'b1;
      ent_d[free_idx].op    = disp_op;
      ent_d[free_idx].src1  = disp_src1_tag;
      ent_d[free_idx].rdy1  = disp_src1_rdy | wk1;
      ent_d[free_idx].src2  = disp_src2_tag;
      ent_d[free_idx].rdy2  = disp_src2_rdy | wk2;
      ent_d[free_idx].dst   = disp_dst_tag;
      ent_d[free_idx].age   = AGE'(count_q) - AGE'(grant_fire);
    end
    if (flush) begin
      valid_d = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_dst_q   <= '0;
      iss_src1_q  <= '0;
      iss_src2_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_dst_q   <= iss_dst_d;
      iss_src1_q  <= iss_src1_d;
      iss_src2_q  <= iss_src2_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign count        = count_q;
  assign iss_valid    = iss_valid_q;
  assign iss_op       = iss_op_q;
  assign iss_dst_tag  = iss_dst_q;
  assign iss_src1_tag = iss_src1_q;
  assign iss_src2_tag = iss_src2_q;

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Directed bench for issue_queue_ctrl: a vector table for the basic flow, then
// hand-written fill/reuse, flush and asynchronous-reset sequences.
module tb_issue_queue_ctrl;

  logic         clk, rst_n, flush;
  logic         disp_valid, disp_ready;
  logic [6:0]   disp_op;
  logic [5:0]   disp_src1_tag, disp_src2_tag, disp_dst_tag;
  logic         disp_src1_rdy, disp_src2_rdy;
  logic         wk_valid;
  logic [5:0]   wk_tag;
  logic [15:0]  sel_req;
  logic [111:0] sel_op;
  logic [79:0]  sel_age;
  logic         gnt_valid;
  logic [3:0]   gnt_addr;
  logic         iss_valid;
  logic [6:0]   iss_op;
  logic [5:0]   iss_dst_tag, iss_src1_tag, iss_src2_tag;
  logic [4:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  issue_queue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .wk_valid(wk_valid), .wk_tag(wk_tag),
    .sel_req(sel_req), .sel_op(sel_op), .sel_age(sel_age),
    .gnt_valid(gnt_valid), .gnt_addr(gnt_addr),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_dst_tag(iss_dst_tag),
    .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic dv; logic [6:0] op; logic [5:0] s1; logic r1; logic [5:0] s2; logic r2;
    logic [5:0] dst; logic wv; logic [5:0] wt; logic gv; logic [3:0] ga; logic fl;
    logic [4:0] e_cnt; logic [15:0] e_req; logic e_iv; logic [6:0] e_op;
    logic [5:0] e_dst; logic e_rdy; logic ca; logic [19:0] e_age;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mkv(
    input logic dv, input logic [6:0] op, input logic [5:0] s1, input logic r1,
    input logic [5:0] s2, input logic r2, input logic [5:0] dst,
    input logic wv, input logic [5:0] wt, input logic gv, input logic [3:0] ga,
    input logic fl, input logic [4:0] e_cnt, input logic [15:0] e_req,
    input logic e_iv, input logic [6:0] e_op, input logic [5:0] e_dst,
    input logic e_rdy, input logic ca, input logic [19:0] e_age);
    vec_t v;
    v.dv = dv; v.op = op; v.s1 = s1; v.r1 = r1; v.s2 = s2; v.r2 = r2; v.dst = dst;
    v.wv = wv; v.wt = wt; v.gv = gv; v.ga = ga; v.fl = fl;
    v.e_cnt = e_cnt; v.e_req = e_req; v.e_iv = e_iv; v.e_op = e_op;
    v.e_dst = e_dst; v.e_rdy = e_rdy; v.ca = ca; v.e_age = e_age;
    return v;
  endfunction

  // Ages of entries 0..3 packed as they appear in sel_age[19:0]
  function automatic logic [19:0] ag(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; disp_valid = 0; disp_op = 0; disp_src1_tag = 0; disp_src1_rdy = 0;
    disp_src2_tag = 0; disp_src2_rdy = 0; disp_dst_tag = 0;
    wk_valid = 0; wk_tag = 0; gnt_valid = 0; gnt_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch_ready(input logic [6:0] op);
    disp_valid = 1; disp_op = op; disp_src1_tag = 6'd1; disp_src1_rdy = 1;
    disp_src2_tag = 6'd2; disp_src2_rdy = 1; disp_dst_tag = 6'd40;
  endtask

  logic [79:0] exp_age;

  initial begin
    idle_inputs();
    rst_n = 0;
    #12 rst_n = 1;
    #1;
    chk("reset count", 80'(count), 80'd0);
    chk("reset disp_ready", 80'(disp_ready), 80'd1);
    chk("reset sel_req", 80'(sel_req), 80'd0);
    chk("reset iss_valid", 80'(iss_valid), 80'd0);
    chk("reset iss_op", 80'(iss_op), 80'd0);
    chk("reset sel_age", sel_age, 80'd0);

    vecs[0]  = mkv(1,'h11,1,1,2,1,10, 0,0, 0,0,0, 1,'h0001, 0,0,0, 1,1, ag(0,0,0,0));
    vecs[1]  = mkv(1,'h12,1,1,2,1,11, 0,0, 0,0,0, 2,'h0003, 0,0,0, 1,1, ag(0,1,0,0));
    vecs[2]  = mkv(1,'h13,1,1,2,1,12, 0,0, 0,0,0, 3,'h0007, 0,0,0, 1,1, ag(0,1,2,0));
    vecs[3]  = mkv(0,0,0,0,0,0,0,     0,0, 1,0,0, 2,'h0006, 1,'h11,10, 1,1, ag(0,0,1,0));
    vecs[4]  = mkv(0,0,0,0,0,0,0,     0,0, 0,0,0, 2,'h0006, 0,0,0, 1,1, ag(0,0,1,0));
    vecs[5]  = mkv(1,'h14,5,0,2,1,13, 0,0, 0,0,0, 3,'h0006, 0,0,0, 1,1, ag(2,0,1,0));
    vecs[6]  = mkv(0,0,0,0,0,0,0,     1,5, 0,0,0, 3,'h0007, 0,0,0, 1,1, ag(2,0,1,0));
    vecs[7]  = mkv(0,0,0,0,0,0,0,     0,0, 1,3,0, 3,'h0007, 0,0,0, 1,1, ag(2,0,1,0));
    vecs[8]  = mkv(1,'h15,7,1,9,0,14, 0,0, 0,0,0, 4,'h0007, 0,0,0, 1,1, ag(2,0,1,3));
    vecs[9]  = mkv(0,0,0,0,0,0,0,     0,0, 1,3,0, 4,'h0007, 0,0,0, 1,1, ag(2,0,1,3));
    vecs[10] = mkv(1,'h16,9,0,3,1,15, 1,9, 0,0,0, 5,'h001F, 0,0,0, 1,1, ag(2,0,1,3));
    vecs[11] = mkv(1,'h17,1,1,2,1,16, 0,0, 1,1,0, 5,'h003D, 1,'h12,11, 1,1, ag(1,0,0,2));
    vecs[12] = mkv(1,'h18,1,1,2,1,17, 0,0, 1,0,1, 0,'h0000, 0,0,0, 1,0, ag(0,0,0,0));

    for (int i = 0; i < 13; i++) begin
      disp_valid = vecs[i].dv; disp_op = vecs[i].op;
      disp_src1_tag = vecs[i].s1; disp_src1_rdy = vecs[i].r1;
      disp_src2_tag = vecs[i].s2; disp_src2_rdy = vecs[i].r2;
      disp_dst_tag = vecs[i].dst; wk_valid = vecs[i].wv; wk_tag = vecs[i].wt;
      gnt_valid = vecs[i].gv; gnt_addr = vecs[i].ga; flush = vecs[i].fl;
      tick();
      chk($sformatf("v%0d count", i), 80'(count), 80'(vecs[i].e_cnt));
      chk($sformatf("v%0d sel_req", i), 80'(sel_req), 80'(vecs[i].e_req));
      chk($sformatf("v%0d iss_valid", i), 80'(iss_valid), 80'(vecs[i].e_iv));
      chk($sformatf("v%0d disp_ready", i), 80'(disp_ready), 80'(vecs[i].e_rdy));
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d iss_op", i), 80'(iss_op), 80'(vecs[i].e_op));
        chk($sformatf("v%0d iss_dst", i), 80'(iss_dst_tag), 80'(vecs[i].e_dst));
      end
      if (vecs[i].ca) chk($sformatf("v%0d ages", i), 80'(sel_age[19:0]), 80'(vecs[i].e_age));
    end
    idle_inputs();

    // Fill to 16, then grant 7 with a blocked dispatch, then reuse slot 7
    for (int i = 0; i < 16; i++) begin
      dispatch_ready(7'(8'h20 + i));
      tick();
    end
    idle_inputs();
    chk("full count", 80'(count), 80'd16);
    chk("full disp_ready", 80'(disp_ready), 80'd0);
    chk("full sel_req", 80'(sel_req), 80'hFFFF);
    for (int i = 0; i < 16; i++) exp_age[i*5 +: 5] = 5'(i);
    chk("full ages", sel_age, exp_age);

    dispatch_ready(7'h66);
    gnt_valid = 1; gnt_addr = 4'd7;
    tick();
    idle_inputs();
    chk("full grant count", 80'(count), 80'd15);
    chk("full grant iss_valid", 80'(iss_valid), 80'd1);
    chk("full grant iss_op", 80'(iss_op), 80'h27);
    chk("full grant sel_req", 80'(sel_req), 80'hFF7F);
    for (int i = 8; i < 16; i++) exp_age[i*5 +: 5] = 5'(i - 1);
    chk("full grant ages", sel_age, exp_age);

    dispatch_ready(7'h55);
    tick();
    idle_inputs();
    chk("reuse count", 80'(count), 80'd16);
    chk("reuse slot7 op", 80'(sel_op[49 +: 7]), 80'h55);
    chk("reuse slot7 age", 80'(sel_age[35 +: 5]), 80'd15);
    chk("reuse iss_valid", 80'(iss_valid), 80'd0);
    chk("reuse sel_req", 80'(sel_req), 80'hFFFF);

    // Flush with 10 entries plus concurrent dispatch and legal grant
    flush = 1;
    tick();
    idle_inputs();
    chk("preflush count", 80'(count), 80'd0);
    for (int i = 0; i < 10; i++) begin
      dispatch_ready(7'(8'h30 + i));
      tick();
    end
    chk("ten count", 80'(count), 80'd10);
    dispatch_ready(7'h77);
    gnt_valid = 1; gnt_addr = 4'd2; flush = 1;
    tick();
    idle_inputs();
    chk("flush count", 80'(count), 80'd0);
    chk("flush sel_req", 80'(sel_req), 80'd0);
    chk("flush iss_valid", 80'(iss_valid), 80'd0);
    chk("flush disp_ready", 80'(disp_ready), 80'd1);
    tick();
    chk("post flush count", 80'(count), 80'd0);

    // Asynchronous reset between clock edges
    for (int i = 0; i < 3; i++) begin
      dispatch_ready(7'(8'h40 + i));
      tick();
    end
    idle_inputs();
    gnt_valid = 1; gnt_addr = 4'd0;
    tick();
    idle_inputs();
    chk("pre-reset iss_valid", 80'(iss_valid), 80'd1);
    chk("pre-reset iss_op", 80'(iss_op), 80'h40);
    #2 rst_n = 0;
    #1;
    chk("async rst count", 80'(count), 80'd0);
    chk("async rst sel_req", 80'(sel_req), 80'd0);
    chk("async rst iss_valid", 80'(iss_valid), 80'd0);
    #3 rst_n = 1;
    tick();
    chk("after rst count", 80'(count), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
